// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : VGA mode descriptor type, mode table and shared timing helpers.
// Revision : 1.0 - multi-mode table added alongside the legacy 800x600 aliases
// ============================================================================
package vga_pkg;

    localparam int VGA_NUM_MODES = 2;
    localparam int VGA_CNT_W     = 11;

    typedef struct packed {
        logic [VGA_CNT_W-1:0] h_active;
        logic [VGA_CNT_W-1:0] h_total;
        logic [VGA_CNT_W-1:0] h_sync_start;
        logic [VGA_CNT_W-1:0] h_sync_end;
        logic [VGA_CNT_W-1:0] v_active;
        logic [VGA_CNT_W-1:0] v_total;
        logic [VGA_CNT_W-1:0] v_sync_start;
        logic [VGA_CNT_W-1:0] v_sync_end;
        logic                 hsync_pol;
        logic                 vsync_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 11'd800, h_total: 11'd1056, h_sync_start: 11'd840, h_sync_end: 11'd967,
        v_active: 11'd600, v_total: 11'd628,  v_sync_start: 11'd601, v_sync_end: 11'd604,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 11'd640, h_total: 11'd800,  h_sync_start: 11'd656, h_sync_end: 11'd751,
        v_active: 11'd480, v_total: 11'd525,  v_sync_start: 11'd490, v_sync_end: 11'd491,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };

    // Index 0 sits in the low bits of the packed table.
    localparam vga_mode_t [VGA_NUM_MODES-1:0] VGA_MODES = {MODE_640X480_60, MODE_800X600_60};

    localparam int HOR_ACTIVE     = int'(VGA_MODES[0].h_active);
    localparam int HOR_TOTAL      = int'(VGA_MODES[0].h_total);
    localparam int HOR_SYNC_START = int'(VGA_MODES[0].h_sync_start);
    localparam int HOR_SYNC_END   = int'(VGA_MODES[0].h_sync_end);
    localparam int VER_ACTIVE     = int'(VGA_MODES[0].v_active);
    localparam int VER_TOTAL      = int'(VGA_MODES[0].v_total);
    localparam int VER_SYNC_START = int'(VGA_MODES[0].v_sync_start);
    localparam int VER_SYNC_END   = int'(VGA_MODES[0].v_sync_end);

    function automatic logic in_window(input logic [31:0] val, input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_multi.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_multi
// Brief    : Multi-mode VGA timing generator with frame-boundary mode switching.
// Revision : 1.0 - initial multi-mode release
// ============================================================================
module vga_timing_multi
    import vga_pkg::*;
#(
    parameter int                        NUM_MODES  = VGA_NUM_MODES,
    parameter int                        CNT_W      = VGA_CNT_W,
    parameter int                        MODE_RST   = 0,
    parameter vga_mode_t [NUM_MODES-1:0] MODE_TABLE = VGA_MODES,
    localparam int                       MODE_W     = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              en,
    output logic [CNT_W-1:0]  hcount,
    output logic [CNT_W-1:0]  vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              hblnk,
    output logic              vblnk,
    output logic              frame_start,
    output logic [MODE_W-1:0] active_mode,
    output logic              mode_pending
);

    localparam logic [MODE_W-1:0] c_mode_rst   = MODE_W'(MODE_RST);
    localparam logic              c_hsync_idle = ~MODE_TABLE[MODE_RST].hsync_pol;
    localparam logic              c_vsync_idle = ~MODE_TABLE[MODE_RST].vsync_pol;

    logic [CNT_W-1:0]  r_hcount_q, w_hcount_d;
    logic [CNT_W-1:0]  r_vcount_q, w_vcount_d;
    logic [MODE_W-1:0] r_active_mode_q, w_active_mode_d;
    logic [MODE_W-1:0] r_pending_mode_q, w_pending_mode_d;
    logic              r_mode_pending_q, w_mode_pending_d;
    logic              r_hsync_q, w_hsync_d;
    logic              r_vsync_q, w_vsync_d;
    logic              r_hblnk_q, w_hblnk_d;
    logic              r_vblnk_q, w_vblnk_d;
    logic              r_frame_start_q, w_frame_start_d;
    logic              w_sel_valid;
    logic              w_h_last;
    logic              w_v_last;

    always_comb begin
        w_hcount_d       = r_hcount_q;
        w_vcount_d       = r_vcount_q;
        w_active_mode_d  = r_active_mode_q;
        w_pending_mode_d = r_pending_mode_q;
        w_mode_pending_d = r_mode_pending_q;

        w_sel_valid = 32'(mode_sel) < 32'(NUM_MODES);
        w_h_last    = 32'(r_hcount_q) == 32'(MODE_TABLE[r_active_mode_q].h_total) - 32'd1;
        w_v_last    = 32'(r_vcount_q) == 32'(MODE_TABLE[r_active_mode_q].v_total) - 32'd1;

        if (en) begin
            if (w_sel_valid) begin
                w_pending_mode_d = mode_sel;
                w_mode_pending_d = (mode_sel != r_active_mode_q);
            end
            if (w_h_last) begin
                w_hcount_d = '0;
                if (w_v_last) begin
                    w_vcount_d = '0;
                    // A request seen on the last pixel itself lands on this boundary.
                    if (w_mode_pending_d) begin
                        w_active_mode_d  = w_pending_mode_d;
                        w_mode_pending_d = 1'b0;
                    end
                end else begin
                    w_vcount_d = r_vcount_q + CNT_W'(1);
                end
            end else begin
                w_hcount_d = r_hcount_q + CNT_W'(1);
            end
        end

        // Decode from next-state values so every output lines up with its counters.
        w_hsync_d = in_window(32'(w_hcount_d),
                              32'(MODE_TABLE[w_active_mode_d].h_sync_start),
                              32'(MODE_TABLE[w_active_mode_d].h_sync_end))
                    ? MODE_TABLE[w_active_mode_d].hsync_pol
                    : ~MODE_TABLE[w_active_mode_d].hsync_pol;
        w_vsync_d = in_window(32'(w_vcount_d),
                              32'(MODE_TABLE[w_active_mode_d].v_sync_start),
                              32'(MODE_TABLE[w_active_mode_d].v_sync_end))
                    ? MODE_TABLE[w_active_mode_d].vsync_pol
                    : ~MODE_TABLE[w_active_mode_d].vsync_pol;
        w_hblnk_d       = 32'(w_hcount_d) >= 32'(MODE_TABLE[w_active_mode_d].h_active);
        w_vblnk_d       = 32'(w_vcount_d) >= 32'(MODE_TABLE[w_active_mode_d].v_active);
        w_frame_start_d = (w_hcount_d == '0) && (w_vcount_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount_q       <= '0;
            r_vcount_q       <= '0;
            r_active_mode_q  <= c_mode_rst;
            r_pending_mode_q <= c_mode_rst;
            r_mode_pending_q <= 1'b0;
            r_hsync_q        <= c_hsync_idle;
            r_vsync_q        <= c_vsync_idle;
            r_hblnk_q        <= 1'b0;
            r_vblnk_q        <= 1'b0;
            r_frame_start_q  <= 1'b1;
        end else begin
            r_hcount_q       <= w_hcount_d;
            r_vcount_q       <= w_vcount_d;
            r_active_mode_q  <= w_active_mode_d;
            r_pending_mode_q <= w_pending_mode_d;
            r_mode_pending_q <= w_mode_pending_d;
            r_hsync_q        <= w_hsync_d;
            r_vsync_q        <= w_vsync_d;
            r_hblnk_q        <= w_hblnk_d;
            r_vblnk_q        <= w_vblnk_d;
            r_frame_start_q  <= w_frame_start_d;
        end
    end

    assign hcount       = r_hcount_q;
    assign vcount       = r_vcount_q;
    assign hsync        = r_hsync_q;
    assign vsync        = r_vsync_q;
    assign hblnk        = r_hblnk_q;
    assign vblnk        = r_vblnk_q;
    assign frame_start  = r_frame_start_q;
    assign active_mode  = r_active_mode_q;
    assign mode_pending = r_mode_pending_q;

endmodule
`default_nettype wire
